// File: rtl/axil_reg_bank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
// Response codes, channel FSM states, address helper.
package axil_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg_bank_wmerge.sv
// Byte-strobe merge of a register's old value with write data.
// Purely combinational; one byte lane per strobe bit.
module axil_reg_bank_wmerge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_val,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // replace each strobed byte lane, keep the rest
  always_comb begin
    merged = old_val;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank with RO status slots and write pulses.
// Define AXIL_REG_BANK_SLVERR_EN for SLVERR on bad/RO accesses.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_ready_q, w_ready_q;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  ar_ready_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata_e;
  logic [STRB_W-1:0]     wstrb_e;
  logic [IDX_W-1:0]      widx, ridx;
  logic [NUM_REGS-1:0]   w_sel, r_sel;
  logic                  w_in, r_in;
  logic                  w_err, r_err;
  logic [DATA_WIDTH-1:0] w_old, w_new, r_val;
  logic [1:0]            w_resp, r_resp;

  assign aw_hs = aw_ready_q & S_AXI_AWVALID;
  assign w_hs  = w_ready_q & S_AXI_WVALID;
  assign ar_hs = ar_ready_q & S_AXI_ARVALID;

  // a handshake in the current cycle counts as already held
  assign commit = (wr_state == WR_IDLE)
                & (aw_done | aw_hs)
                & (w_done | w_hs);

  assign waddr   = aw_done ? addr_q  : S_AXI_AWADDR;
  assign wdata_e = w_done  ? wdata_q : S_AXI_WDATA;
  assign wstrb_e = w_done  ? wstrb_q : S_AXI_WSTRB;

  assign widx = waddr[ADDR_WIDTH-1:ADDR_LSB];
  assign ridx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_in = int'(widx) < NUM_REGS;
  assign r_in = int'(ridx) < NUM_REGS;

  // one-hot decode of write and read targets
  always_comb begin
    w_sel = '0;
    r_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = (int'(widx) == i);
      r_sel[i] = (int'(ridx) == i);
    end
  end

  // old value of the write target, read mux
  always_comb begin
    w_old = '0;
    r_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel[i]) w_old = regs[i];
      if (r_sel[i]) begin
        r_val = RO_MASK[i]
              ? hw_status[i*DATA_WIDTH +: DATA_WIDTH]
              : regs[i];
      end
    end
  end

  assign w_err  = ~w_in | (|(w_sel & RO_MASK));
  assign r_err  = ~r_in;
  assign w_resp = (ERR_EN && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign r_resp = (ERR_EN && r_err) ? RESP_SLVERR : RESP_OKAY;

  axil_reg_bank_wmerge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wmerge (
    .old_val (w_old),
    .wdata   (wdata_e),
    .wstrb   (wstrb_e),
    .merged  (w_new)
  );

  // channel state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // write channel next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_next = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // read channel next state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // AW/W holding registers, readies and B response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (commit) begin
        aw_ready_q <= 1'b0;
        w_ready_q  <= 1'b0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        bvalid_q   <= 1'b1;
        bresp_q    <= w_resp;
      end else begin
        if (aw_hs) begin
          aw_ready_q <= 1'b0;
          aw_done    <= 1'b1;
          addr_q     <= S_AXI_AWADDR;
        end else if (!aw_done) begin
          aw_ready_q <= 1'b1;
        end
        if (w_hs) begin
          w_ready_q <= 1'b0;
          w_done    <= 1'b1;
          wdata_q   <= S_AXI_WDATA;
          wstrb_q   <= S_AXI_WSTRB;
        end else if (!w_done) begin
          w_ready_q <= 1'b1;
        end
      end
    end else if (S_AXI_BREADY) begin
      bvalid_q   <= 1'b0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
    end
  end

  // register storage and per-register write pulses
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
    end else begin
      wr_pulse <= commit ? (w_sel & ~RO_MASK) : '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && w_sel[i] && !RO_MASK[i]) begin
          regs[i] <= w_new;
        end
      end
    end
  end

  // AR capture and R response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs) begin
        ar_ready_q <= 1'b0;
        rvalid_q   <= 1'b1;
        rresp_q    <= r_resp;
        rdata_q    <= r_val;
      end else begin
        ar_ready_q <= 1'b1;
      end
    end else if (S_AXI_RREADY) begin
      rvalid_q   <= 1'b0;
      ar_ready_q <= 1'b1;
    end
  end

  // flattened register view, RO slots read as zero
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       waddr[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank.
// 32-bit, 8 registers, register 7 read-only.
module tb_axil_reg_bank;

`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [5:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b1;
  logic [5:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b1;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;
  logic [255:0] hw_status = '0;

  int compared = 0;
  int mismatched = 0;

  always #5 ACLK = ~ACLK;

  axil_reg_bank #(
    .DATA_WIDTH (32),
    .NUM_REGS   (8),
    .ADDR_WIDTH (6),
    .RO_MASK    (8'h80),
    .RESET_VAL  (32'h0)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .wr_pulse      (wr_pulse),
    .hw_status     (hw_status)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AW then W (W delayed by wdelay cycles); checks B and pulse
  task automatic wr(input logic [5:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int wdelay,
                    input logic [7:0] pulse, input logic [1:0] resp);
    int cyc;
    bit aw_p, w_p, fa, fw;
    cyc = 0; aw_p = 1; w_p = 1;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    while ((aw_p || w_p) && cyc < 40) begin
      S_AXI_AWVALID = aw_p;
      S_AXI_WVALID = w_p && (cyc >= wdelay);
      fa = S_AXI_AWVALID && S_AXI_AWREADY;
      fw = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      cyc++;
      if (fa) aw_p = 0;
      if (fw) w_p = 0;
      if (aw_p || w_p) chk("bvalid_early", S_AXI_BVALID, 1'b0);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("wr_timeout", {aw_p, w_p}, 2'b00);
    chk("bvalid", S_AXI_BVALID, 1'b1);
    chk("bresp", S_AXI_BRESP, resp);
    chk("pulse_on", wr_pulse, pulse);
    @(negedge ACLK);
    chk("pulse_off", wr_pulse, 8'h00);
    chk("bvalid_off", S_AXI_BVALID, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] d,
                    input logic [1:0] resp);
    int cyc;
    bit p, f;
    cyc = 0; p = 1;
    S_AXI_ARADDR = a;
    while (p && cyc < 40) begin
      S_AXI_ARVALID = 1;
      f = S_AXI_ARREADY;
      @(negedge ACLK);
      cyc++;
      if (f) p = 0;
    end
    S_AXI_ARVALID = 0;
    chk("rd_timeout", p, 1'b0);
    chk("rvalid", S_AXI_RVALID, 1'b1);
    chk("rdata", S_AXI_RDATA, d);
    chk("rresp", S_AXI_RRESP, resp);
    @(negedge ACLK);
    chk("rvalid_off", S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    hw_status[31:0]    = 32'hFFFF_FFFF;
    hw_status[255:224] = 32'hCAFE_0001;

    // reset state
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", S_AXI_AWREADY, 1'b0);
    chk("rst_arready", S_AXI_ARREADY, 1'b0);
    chk("rst_bvalid", S_AXI_BVALID, 1'b0);
    chk("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("rst_regq", reg_q[63:0], 64'h0);
    ARESETN = 1;
    #1 chk("rel_awready", S_AXI_AWREADY, 1'b0);
    @(negedge ACLK);
    chk("up_readies",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // sequential writes and read-back
    wr(6'h00, 32'h1, 4'hF, 0, 8'h01, 2'b00);
    wr(6'h04, 32'h2, 4'hF, 0, 8'h02, 2'b00);
    wr(6'h08, 32'h3, 4'hF, 0, 8'h04, 2'b00);
    wr(6'h0C, 32'h4, 4'hF, 0, 8'h08, 2'b00);
    chk("regq_0_3", reg_q[127:0],
        128'h00000004_00000003_00000002_00000001);
    rd(6'h00, 32'h1, 2'b00);
    rd(6'h04, 32'h2, 2'b00);
    rd(6'h08, 32'h3, 2'b00);
    rd(6'h0C, 32'h4, 2'b00);

    // partial strobe
    wr(6'h08, 32'hDEAD_BEEF, 4'b0011, 0, 8'h04, 2'b00);
    rd(6'h08, 32'h0000_BEEF, 2'b00);

    // AW three cycles ahead of W
    wr(6'h10, 32'hA5A5_A5A5, 4'hF, 3, 8'h10, 2'b00);
    rd(6'h10, 32'hA5A5_A5A5, 2'b00);

    // read-only slot
    wr(6'h1C, 32'h1234_5678, 4'hF, 0, 8'h00, EXP_ERR);
    rd(6'h1C, 32'hCAFE_0001, 2'b00);
    chk("regq_ro", reg_q[255:224], 32'h0);

    // out of range
    wr(6'h20, 32'h9999_9999, 4'hF, 0, 8'h00, EXP_ERR);
    rd(6'h20, 32'h0, EXP_ERR);
    chk("regq_oor", reg_q[223:0],
        {32'h0, 32'h0, 32'hA5A5_A5A5, 32'h4,
         32'h0000_BEEF, 32'h2, 32'h1});
    // RW slot 0 must ignore hw_status
    rd(6'h00, 32'h1, 2'b00);

    // read and write commit on the same edge
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h55;
    S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h04;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    chk("same_rdata", S_AXI_RDATA, 32'h2);
    chk("same_regq", reg_q[63:32], 32'h55);
    chk("same_pulse", wr_pulse, 8'h02);
    @(negedge ACLK);
    @(negedge ACLK);

    // reset while responses are pending
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h77;
    S_AXI_ARADDR = 6'h0C;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    @(negedge ACLK);
    chk("hold_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    chk("hold_reg0", reg_q[31:0], 32'h77);
    #2 ARESETN = 0;
    #1;
    chk("ar_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("ar_readies",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("ar_regq", reg_q[127:0], 128'h0);
    @(negedge ACLK);
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    ARESETN = 1;
    #1 chk("ar_rel_ready", S_AXI_AWREADY, 1'b0);
    @(negedge ACLK);
    chk("ar_up_readies",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    rd(6'h00, 32'h0, 2'b00);
    wr(6'h14, 32'h0BAD_F00D, 4'hF, 0, 8'h20, 2'b00);
    rd(6'h14, 32'h0BAD_F00D, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
